fwd_hazard_unit: RTL and testbench

//  Parametrised EX-stage operand forwarding and load-use stall unit for the 5-stage pipeline.

---
 rtl/fwd_hazard_unit_pkg.sv | 22 ++
 rtl/fwd_hazard_unit_wb_history.sv | 67 ++++++
 rtl/fwd_hazard_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit_pkg
//   Shared definitions for the EX-stage forwarding / load-use stall unit:
//   forwarding source codes reported on FwdSelE, the stall FSM state type and
//   the width of the bubble down-counter.
// -----------------------------------------------------------------------------
package fwd_hazard_unit_pkg;

    // Source codes for a forwarded operand; history entry k reports FWD_HIST_BASE + k.
    localparam int FWD_REG       = 0;
    localparam int FWD_MEM       = 1;
    localparam int FWD_WB        = 2;
    localparam int FWD_HIST_BASE = 3;

    localparam int BUB_CNT_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } stall_state_e;

endpackage

// File: rtl/fwd_hazard_unit_wb_history.sv
// -----------------------------------------------------------------------------
// wb_history
//   Shift buffer of recently retired register writes. Every clock one entry is
//   pushed into slot 0 (valid only when the retiring instruction really wrote a
//   non-zero register) and the older entries move down by one; the oldest one
//   falls off the end. Entry 0 is the write that retired on the previous cycle.
//
// Ports
//   Clk, Rst        clock, synchronous active-high reset (clears valid bits)
//   PushValid       retiring write is a real register write
//   PushReg         destination index of the retiring write
//   PushData        value of the retiring write
//   HistValid       per-entry valid, bit k = entry k
//   HistReg         entry indices, packed LSB-first (entry k at k*REG_AW)
//   HistData        entry values, packed LSB-first (entry k at k*DATA_W)
// -----------------------------------------------------------------------------
module wb_history
    import fwd_hazard_unit_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int HIST_DEPTH = 1
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         PushValid,
    input  logic [REG_AW-1:0]            PushReg,
    input  logic [DATA_W-1:0]            PushData,
    output logic [HIST_DEPTH-1:0]        HistValid,
    output logic [HIST_DEPTH*REG_AW-1:0] HistReg,
    output logic [HIST_DEPTH*DATA_W-1:0] HistData
);

    logic [HIST_DEPTH-1:0] validQ;
    logic [REG_AW-1:0]     regQ  [HIST_DEPTH];
    logic [DATA_W-1:0]     dataQ [HIST_DEPTH];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            validQ <= '0;
        end else begin
            validQ[0] <= PushValid;
            for (int k = 1; k < HIST_DEPTH; k++) begin
                validQ[k] <= validQ[k-1];
            end
        end
    end

    // Index/data payload shifts unconditionally; the valid bits alone decide
    // whether an entry can ever match.
    always_ff @(posedge Clk) begin
        regQ[0]  <= PushReg;
        dataQ[0] <= PushData;
        for (int k = 1; k < HIST_DEPTH; k++) begin
            regQ[k]  <= regQ[k-1];
            dataQ[k] <= dataQ[k-1];
        end
    end

    assign HistValid = validQ;

    for (genvar k = 0; k < HIST_DEPTH; k++) begin : g_flat
        assign HistReg[k*REG_AW +: REG_AW]  = regQ[k];
        assign HistData[k*DATA_W +: DATA_W] = dataQ[k];
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//   EX-stage operand forwarding and load-use stall unit for the 5-stage pipe.
//   Each operand lane picks the youngest producer of its source register:
//   M-stage ALU result, W-stage result, then the retired-write history, and
//   otherwise the register-file value. A load in E whose destination is used
//   by the instruction in D stalls F/D and flushes E for LOAD_BUBBLES cycles.
//
// Ports
//   Clk, Rst                 clock, synchronous active-high reset
//   SrcRegE / ReadSrcE       source indices / register-file values of E (lanes LSB-first)
//   SrcRegD / SrcUsedD       source indices / lane-used flags of D
//   RegWriteE, MemtoRegE, WriteRegE            E-stage write info
//   RegWriteM, MemtoRegM, WriteRegM, ALUOutM   M-stage write info and ALU result
//   RegWriteW, WriteRegW, ResultW              W-stage write info and result
//   SrcE                     forwarded operands to the ALU
//   FwdSelE                  per-lane source code (see fwd_hazard_unit_pkg)
//   StallF, StallD, FlushE   hazard controls
//   StallCnt                 saturating count of cycles with StallD=1
// -----------------------------------------------------------------------------
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter  int DATA_W       = 32,
    parameter  int REG_AW       = 5,
    parameter  int NUM_SRC      = 2,
    parameter  int HIST_DEPTH   = 1,
    parameter  int LOAD_BUBBLES = 1,
    localparam int SEL_W        = $clog2(HIST_DEPTH + 3)
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [NUM_SRC*REG_AW-1:0] SrcRegE,
    input  logic [NUM_SRC*DATA_W-1:0] ReadSrcE,
    input  logic [NUM_SRC*REG_AW-1:0] SrcRegD,
    input  logic [NUM_SRC-1:0]        SrcUsedD,
    input  logic                      RegWriteE,
    input  logic                      MemtoRegE,
    input  logic [REG_AW-1:0]         WriteRegE,
    input  logic                      RegWriteM,
    input  logic                      MemtoRegM,
    input  logic [REG_AW-1:0]         WriteRegM,
    input  logic [DATA_W-1:0]         ALUOutM,
    input  logic                      RegWriteW,
    input  logic [REG_AW-1:0]         WriteRegW,
    input  logic [DATA_W-1:0]         ResultW,
    output logic [NUM_SRC*DATA_W-1:0] SrcE,
    output logic [NUM_SRC*SEL_W-1:0]  FwdSelE,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      FlushE,
    output logic [31:0]               StallCnt
);

    function automatic logic [31:0] satInc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [HIST_DEPTH-1:0]        histValid;
    logic [HIST_DEPTH*REG_AW-1:0] histReg;
    logic [HIST_DEPTH*DATA_W-1:0] histData;
    logic                         histPush;

    assign histPush = RegWriteW && (WriteRegW != '0);

    wb_history #(
        .DATA_W     (DATA_W),
        .REG_AW     (REG_AW),
        .HIST_DEPTH (HIST_DEPTH)
    ) u_hist (
        .Clk       (Clk),
        .Rst       (Rst),
        .PushValid (histPush),
        .PushReg   (WriteRegW),
        .PushData  (ResultW),
        .HistValid (histValid),
        .HistReg   (histReg),
        .HistData  (histData)
    );

    // ---- E stage: per-lane operand selection (combinational) ----
    logic [NUM_SRC-1:0] memLoadHit;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
        logic [REG_AW-1:0]     src;
        logic [DATA_W-1:0]     regVal;
        logic                  memHit;
        logic                  wbHit;
        logic [HIST_DEPTH-1:0] histHit;
        logic [DATA_W-1:0]     selVal;
        logic [SEL_W-1:0]      selCode;

        assign src    = SrcRegE[i*REG_AW +: REG_AW];
        assign regVal = ReadSrcE[i*DATA_W +: DATA_W];
        assign memHit = RegWriteM && (WriteRegM == src) && (src != '0);
        assign wbHit  = RegWriteW && (WriteRegW == src) && (src != '0);

        for (genvar k = 0; k < HIST_DEPTH; k++) begin : g_hit
            assign histHit[k] = histValid[k] && (histReg[k*REG_AW +: REG_AW] == src)
                                && (src != '0);
        end

        // A load in M has no data yet; the lane must not take ALUOutM.
        assign memLoadHit[i] = memHit && MemtoRegM;

        // Walk oldest to youngest so the youngest match is the last override.
        always_comb begin
            selVal  = regVal;
            selCode = SEL_W'(FWD_REG);
            for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
                if (histHit[k]) begin
                    selVal  = histData[k*DATA_W +: DATA_W];
                    selCode = SEL_W'(FWD_HIST_BASE + k);
                end
            end
            if (wbHit) begin
                selVal  = ResultW;
                selCode = SEL_W'(FWD_WB);
            end
            if (memHit && !MemtoRegM) begin
                selVal  = ALUOutM;
                selCode = SEL_W'(FWD_MEM);
            end
            if (Rst) begin
                selVal  = regVal;
                selCode = SEL_W'(FWD_REG);
            end
        end

        assign SrcE[i*DATA_W +: DATA_W]  = selVal;
        assign FwdSelE[i*SEL_W +: SEL_W] = selCode;
    end

    // ---- D/E boundary: load-use detection (combinational) ----
    logic loadUseD;

    always_comb begin
        loadUseD = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (SrcUsedD[i] && (SrcRegD[i*REG_AW +: REG_AW] == WriteRegE)) begin
                loadUseD = 1'b1;
            end
        end
        loadUseD = loadUseD && RegWriteE && MemtoRegE && (WriteRegE != '0);
    end

    // ---- Stall sequencer ----
    stall_state_e         state;
    stall_state_e         stateNext;
    logic [BUB_CNT_W-1:0] bubCnt;
    logic [BUB_CNT_W-1:0] bubCntNext;
    logic                 stallReq;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state  <= ST_IDLE;
            bubCnt <= '0;
        end else begin
            state  <= stateNext;
            bubCnt <= bubCntNext;
        end
    end

    // The first bubble is issued from IDLE; HOLD covers the remaining ones.
    always_comb begin
        stateNext  = state;
        bubCntNext = bubCnt;
        stallReq   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (loadUseD) begin
                    stallReq = 1'b1;
                    if (LOAD_BUBBLES > 1) begin
                        stateNext  = ST_HOLD;
                        bubCntNext = BUB_CNT_W'(LOAD_BUBBLES - 1);
                    end
                end
            end
            ST_HOLD: begin
                stallReq   = 1'b1;
                bubCntNext = bubCnt - BUB_CNT_W'(1);
                if (bubCnt == BUB_CNT_W'(1)) begin
                    stateNext = ST_IDLE;
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    assign StallF = stallReq && !Rst;
    assign StallD = stallReq && !Rst;
    assign FlushE = stallReq || Rst;

    logic [31:0] stallCntQ;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stallCntQ <= '0;
        end else if (StallD) begin
            stallCntQ <= satInc(stallCntQ);
        end
    end

    assign StallCnt = stallCntQ;

    // Sticky record of a lane that depended on a load still in M; the stall
    // logic upstream is expected to make this impossible.
    logic errFlag;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            errFlag <= 1'b0;
        end else if (|memLoadHit) begin
            errFlag <= 1'b1;
        end
    end

    assert property (@(posedge Clk) disable iff (Rst) !errFlag);

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

    localparam int DW = 32;
    localparam int AW = 5;

    logic           Clk = 1'b0;
    logic           Rst;
    logic [2*AW-1:0] SrcRegE, SrcRegD;
    logic [2*DW-1:0] ReadSrcE;
    logic [1:0]      SrcUsedD;
    logic            RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW;
    logic [AW-1:0]   WriteRegE, WriteRegM, WriteRegW;
    logic [DW-1:0]   ALUOutM, ResultW;

    logic [2*DW-1:0] srcEA, srcEB;
    logic [3:0]      selA;
    logic [5:0]      selB;
    logic            stallFA, stallDA, flushA, stallFB, stallDB, flushB;
    logic [31:0]     cntA, cntB;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    fwd_hazard_unit #(.DATA_W(DW), .REG_AW(AW), .NUM_SRC(2), .HIST_DEPTH(1), .LOAD_BUBBLES(1)) dutA (
        .Clk(Clk), .Rst(Rst), .SrcRegE(SrcRegE), .ReadSrcE(ReadSrcE), .SrcRegD(SrcRegD),
        .SrcUsedD(SrcUsedD), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM), .ALUOutM(ALUOutM),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
        .SrcE(srcEA), .FwdSelE(selA), .StallF(stallFA), .StallD(stallDA), .FlushE(flushA),
        .StallCnt(cntA));

    fwd_hazard_unit #(.DATA_W(DW), .REG_AW(AW), .NUM_SRC(2), .HIST_DEPTH(2), .LOAD_BUBBLES(3)) dutB (
        .Clk(Clk), .Rst(Rst), .SrcRegE(SrcRegE), .ReadSrcE(ReadSrcE), .SrcRegD(SrcRegD),
        .SrcUsedD(SrcUsedD), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM), .ALUOutM(ALUOutM),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
        .SrcE(srcEB), .FwdSelE(selB), .StallF(stallFB), .StallD(stallDB), .FlushE(flushB),
        .StallCnt(cntB));

    // Reference model: index 0 = dutA (1 history entry, 1 bubble), 1 = dutB (2 entries, 3 bubbles).
    int          HD[2] = '{1, 2};
    int          LB[2] = '{1, 3};
    logic        mhV [2][2];
    logic [4:0]  mhR [2][2];
    logic [31:0] mhD [2][2];
    int          mLeft [2];
    logic [31:0] mCnt [2];
    bit          modelOn = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // Youngest-first list of producers: M (not a load), W, history 0..HD-1.
    function automatic int expCode(input int j, input int lane);
        logic [4:0] s;
        s = SrcRegE[lane*AW +: AW];
        if (s == 5'd0) return 0;
        if (RegWriteM && !MemtoRegM && WriteRegM == s) return 1;
        if (RegWriteW && WriteRegW == s) return 2;
        for (int k = 0; k < HD[j]; k++)
            if (mhV[j][k] && mhR[j][k] == s) return 3 + k;
        return 0;
    endfunction

    function automatic logic [31:0] codeVal(input int j, input int lane, input int code);
        if (code == 0) return ReadSrcE[lane*DW +: DW];
        if (code == 1) return ALUOutM;
        if (code == 2) return ResultW;
        return mhD[j][code-3];
    endfunction

    function automatic bit loadUse();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 2; i++)
            if (SrcUsedD[i] && SrcRegD[i*AW +: AW] == WriteRegE) hit = 1'b1;
        return hit && RegWriteE && MemtoRegE && (WriteRegE != 5'd0);
    endfunction

    function automatic bit expStall(input int j);
        if (Rst) return 1'b0;
        if (mLeft[j] > 0) return 1'b1;
        return loadUse();
    endfunction

    task automatic modelStep();
        for (int j = 0; j < 2; j++) begin
            if (Rst) begin
                mhV[j][0] = 1'b0; mhV[j][1] = 1'b0;
                mLeft[j] = 0;
                mCnt[j] = 32'd0;
            end else begin
                bit st;
                st = expStall(j);
                if (mLeft[j] > 0) mLeft[j] = mLeft[j] - 1;
                else if (st) mLeft[j] = LB[j] - 1;
                if (st && mCnt[j] != 32'hFFFF_FFFF) mCnt[j] = mCnt[j] + 32'd1;
                mhV[j][1] = mhV[j][0]; mhR[j][1] = mhR[j][0]; mhD[j][1] = mhD[j][0];
                mhV[j][0] = RegWriteW && (WriteRegW != 5'd0);
                mhR[j][0] = WriteRegW;
                mhD[j][0] = ResultW;
            end
        end
        if (Rst) modelOn = 1'b1;
    endtask

    task automatic cmpInst(input int j, input logic [63:0] sE, input logic [5:0] sel, input int selW,
                           input logic sf, input logic sd, input logic fe, input logic [31:0] cnt);
        string tag;
        logic [5:0] mask;
        bit es;
        tag  = (j == 0) ? "A" : "B";
        mask = 6'((1 << selW) - 1);
        for (int l = 0; l < 2; l++) begin
            int ec;
            ec = Rst ? 0 : expCode(j, l);
            check($sformatf("%s_src%0d", tag, l), sE[l*DW +: DW], codeVal(j, l, ec));
            check($sformatf("%s_sel%0d", tag, l), 32'((sel >> (l*selW)) & mask), 32'(ec));
        end
        es = expStall(j);
        check({tag, "_StallF"}, 32'(sf), 32'(es));
        check({tag, "_StallD"}, 32'(sd), 32'(es));
        check({tag, "_FlushE"}, 32'(fe), 32'(es || Rst));
        check({tag, "_StallCnt"}, cnt, mCnt[j]);
    endtask

    initial forever begin
        @(posedge Clk);
        modelStep();
    end

    initial forever begin
        @(negedge Clk);
        if (modelOn) begin
            cmpInst(0, srcEA, {2'b00, selA}, 2, stallFA, stallDA, flushA, cntA);
            cmpInst(1, srcEB, selB, 3, stallFB, stallDB, flushB, cntB);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clearIn();
        SrcRegE = '0; ReadSrcE = '0; SrcRegD = '0; SrcUsedD = '0;
        RegWriteE = 0; MemtoRegE = 0; WriteRegE = '0;
        RegWriteM = 0; MemtoRegM = 0; WriteRegM = '0; ALUOutM = '0;
        RegWriteW = 0; WriteRegW = '0; ResultW = '0;
    endtask

    task automatic randIn();
        SrcRegE   = {5'($urandom_range(7)), 5'($urandom_range(7))};
        SrcRegD   = {5'($urandom_range(7)), 5'($urandom_range(7))};
        ReadSrcE  = {$urandom, $urandom};
        SrcUsedD  = 2'($urandom);
        RegWriteE = ($urandom_range(3) != 0);
        MemtoRegE = 1'($urandom);
        WriteRegE = 5'($urandom_range(7));
        RegWriteM = 1'($urandom);
        MemtoRegM = ($urandom_range(3) == 0);
        WriteRegM = 5'($urandom_range(7));
        ALUOutM   = $urandom;
        RegWriteW = 1'($urandom);
        WriteRegW = 5'($urandom_range(7));
        ResultW   = $urandom;
        // A lane depending on a load still in M cannot occur behind a working stall.
        if (RegWriteM && MemtoRegM && WriteRegM != 5'd0 &&
            (WriteRegM == SrcRegE[4:0] || WriteRegM == SrcRegE[9:5]))
            MemtoRegM = 1'b0;
        Rst = ($urandom_range(299) == 0);
    endtask

    initial begin
        clearIn();
        Rst = 1'b1;
        // Forwarding candidate and load-use present during reset must be ignored.
        SrcRegE = {5'd0, 5'd3}; ReadSrcE = {32'h0000_0000, 32'h1234_5678};
        RegWriteM = 1; WriteRegM = 5'd3; ALUOutM = 32'h11;
        RegWriteE = 1; MemtoRegE = 1; WriteRegE = 5'd3; SrcRegD = {5'd0, 5'd3}; SrcUsedD = 2'b01;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst_srcA0", srcEA[31:0], 32'h1234_5678);
        check("rst_selA0", 32'(selA[1:0]), 32'd0);
        check("rst_stallF", 32'(stallFA), 32'd0);
        check("rst_flushE", 32'(flushB), 32'd1);
        check("rst_cnt", cntB, 32'd0);

        // R-R back-to-back from M.
        tick(); Rst = 1'b0; clearIn();
        SrcRegE = {5'd0, 5'd3}; ReadSrcE = {32'h0BAD_0001, 32'h0BAD_0000};
        RegWriteM = 1; WriteRegM = 5'd3; ALUOutM = 32'h11;
        @(negedge Clk);
        check("t1_srcA0", srcEA[31:0], 32'h11);
        check("t1_selA0", 32'(selA[1:0]), 32'd1);
        check("t1_srcB0", srcEB[31:0], 32'h11);
        check("t1_srcA1", srcEA[63:32], 32'h0BAD_0001);

        // M beats W; r0 never forwarded; W beats history.
        tick(); clearIn();
        SrcRegE = {5'd5, 5'd0}; ReadSrcE = {32'h5151_5151, 32'h5050_5050};
        RegWriteM = 1; WriteRegM = 5'd5; ALUOutM = 32'hAA;
        RegWriteW = 1; WriteRegW = 5'd5; ResultW = 32'hBB;
        @(negedge Clk);
        check("t2_srcA1", srcEA[63:32], 32'hAA);
        check("t2_selB1", 32'(selB[5:3]), 32'd1);
        check("t2_srcA0_r0", srcEA[31:0], 32'h5050_5050);
        tick();
        SrcRegE = '0; WriteRegM = 5'd0; WriteRegW = 5'd0;
        @(negedge Clk);
        check("t2_r0_srcB1", srcEB[63:32], 32'h5151_5151);
        check("t2_r0_selB1", 32'(selB[5:3]), 32'd0);
        tick();
        RegWriteM = 0; WriteRegW = 5'd5; ResultW = 32'hCC; SrcRegE = {5'd5, 5'd0};
        @(negedge Clk);
        check("t2_wb_srcB1", srcEB[63:32], 32'hCC);
        check("t2_wb_selB1", 32'(selB[5:3]), 32'd2);
        tick(); clearIn();
        repeat (3) tick();

        // History depth: r7 written twice, read after retirement.
        RegWriteW = 1; WriteRegW = 5'd7; ResultW = 32'h22;
        tick(); ResultW = 32'h33;
        tick(); RegWriteW = 0; SrcRegE = {5'd0, 5'd7}; ReadSrcE = {32'h0, 32'h777};
        @(negedge Clk);
        check("t3_srcB0", srcEB[31:0], 32'h33);
        check("t3_selB0", 32'(selB[2:0]), 32'd3);
        check("t3_srcA0", srcEA[31:0], 32'h33);
        tick();
        @(negedge Clk);
        check("t3_old_srcB0", srcEB[31:0], 32'h33);
        check("t3_old_selB0", 32'(selB[2:0]), 32'd4);
        check("t3_old_srcA0", srcEA[31:0], 32'h777);
        check("t3_old_selA0", 32'(selA[1:0]), 32'd0);

        // Load-use.
        tick(); clearIn();
        RegWriteE = 1; MemtoRegE = 1; WriteRegE = 5'd2; SrcRegD = {5'd0, 5'd2}; SrcUsedD = 2'b00;
        @(negedge Clk);
        check("t4_unused_stall", 32'(stallDA), 32'd0);
        tick(); SrcUsedD = 2'b01;
        @(negedge Clk);
        check("t4_stallF", 32'(stallFA), 32'd1);
        check("t4_flushE", 32'(flushA), 32'd1);
        check("t4_cnt0", cntA, 32'd0);
        tick(); RegWriteE = 0;
        @(negedge Clk);
        check("t4_A_done", 32'(stallDA), 32'd0);
        check("t4_A_cnt1", cntA, 32'd1);
        check("t4_B_hold1", 32'(stallDB), 32'd1);
        tick();
        @(negedge Clk);
        check("t5_B_hold2", 32'(stallFB), 32'd1);
        tick();
        @(negedge Clk);
        check("t5_B_done", 32'(stallDB), 32'd0);
        check("t5_B_cnt3", cntB, 32'd3);
        tick(); RegWriteE = 1; WriteRegE = 5'd0; SrcRegD = '0; SrcUsedD = 2'b11;
        @(negedge Clk);
        check("t4_r0_load", 32'(stallDA), 32'd0);

        // Reset in the middle of a three-bubble sequence.
        tick(); WriteRegE = 5'd2; SrcRegD = {5'd2, 5'd0}; SrcUsedD = 2'b10;
        @(negedge Clk);
        check("t5_lane1_stall", 32'(stallDB), 32'd1);
        tick(); RegWriteE = 0; Rst = 1'b1;
        @(negedge Clk);
        check("t5_rst_stallF", 32'(stallFB), 32'd0);
        check("t5_rst_flushE", 32'(flushB), 32'd1);
        tick(); Rst = 1'b0;
        @(negedge Clk);
        check("t5_after_stall", 32'(stallDB), 32'd0);
        check("t5_after_cnt", cntB, 32'd0);

        // Random regression against the model.
        for (int n = 0; n < 10000; n++) begin
            tick();
            randIn();
        end
        tick(); Rst = 1'b0; clearIn();
        @(negedge Clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
